// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - Widths, depths and shared types for the register-file write port arbiter
package wb_port_arbiter_pkg;

  localparam int DSIZE        = 16;
  localparam int ASIZE        = 4;
  localparam int WBA_DEPTH    = 2;
  localparam int WBA_MAX_WAIT = 3;

  localparam int CNT_W  = $clog2(WBA_DEPTH + 1);
  localparam int PTR_W  = $clog2(WBA_DEPTH);
  localparam int WAIT_W = $clog2(WBA_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FORCE
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } pend_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - Pipeline, multi-cycle unit and register-file port signals
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic             wb_we;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_wdata;
  logic             cp_valid;
  logic [ASIZE-1:0] cp_waddr;
  logic [DSIZE-1:0] cp_wdata;
  logic             cp_ready;
  logic             rf_we;
  logic [ASIZE-1:0] rf_waddr;
  logic [DSIZE-1:0] rf_wdata;
  logic             stall_pipe;
  logic [CNT_W-1:0] pend_cnt;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, cp_valid, cp_waddr, cp_wdata,
    output cp_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, pend_cnt
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata, cp_valid, cp_waddr, cp_wdata,
    input  cp_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, pend_cnt
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// rtl/wb_pend_fifo.sv - In-order buffer of multi-cycle results with per-entry valid and address cancel
module wb_pend_fifo
  import wb_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [ASIZE-1:0] push_addr_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             cancel_i,
  input  logic [ASIZE-1:0] cancel_addr_i,
  output logic             head_present_o,
  output pend_entry_t      head_o,
  output logic [CNT_W-1:0] cnt_o
);

  pend_entry_t      ent_q [WBA_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] wr_ptr;

  assign wr_ptr = rd_ptr_q + cnt_q[PTR_W-1:0];

  // Cancel is applied before the push so an entry arriving alongside a matching write survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WBA_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (cancel_i) begin
        for (int i = 0; i < WBA_DEPTH; i++) begin
          if (ent_q[i].addr == cancel_addr_i) begin
            ent_q[i].valid <= 1'b0;
          end
        end
      end
      if (push_i) begin
        ent_q[wr_ptr] <= '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_present_o = (cnt_q != '0);
  assign head_o         = ent_q[rd_ptr_q];
  assign cnt_o          = cnt_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - Shares the single register-file write port between pipeline and multi-cycle unit
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;
  logic              cp_ready_q, cp_ready_d;
  logic              rf_we_q, rf_we_d;
  logic [ASIZE-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DSIZE-1:0]  rf_wdata_q, rf_wdata_d;

  logic              push, pop, pipe_grant;
  logic              head_present;
  pend_entry_t       head;
  logic [CNT_W-1:0]  fifo_cnt, cnt_after;

  assign push = bus.cp_valid & cp_ready_q;

  wb_pend_fifo u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .push_addr_i    (bus.cp_waddr),
    .push_data_i    (bus.cp_wdata),
    .pop_i          (pop),
    .cancel_i       (pipe_grant),
    .cancel_addr_i  (bus.wb_waddr),
    .head_present_o (head_present),
    .head_o         (head),
    .cnt_o          (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      stall_q    <= 1'b0;
      cp_ready_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
      cp_ready_q <= cp_ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // An invalid head never needs the port, so it is dropped even while the pipeline writes.
  always_comb begin
    pipe_grant = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      ST_FORCE: pop = head_present;
      default: begin
        pipe_grant = bus.wb_we;
        pop        = head_present & (~head.valid | ~bus.wb_we);
      end
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop && head.valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
    end else if (pipe_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.wb_waddr;
      rf_wdata_d = bus.wb_wdata;
    end
  end

  always_comb begin
    cnt_after  = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    cp_ready_d = (cnt_after < CNT_W'(WBA_DEPTH));
    wait_d     = '0;
    state_d    = (cnt_after != '0) ? ST_PEND : ST_IDLE;
    if (state_q == ST_PEND && !pop) begin
      wait_d = wait_q + 1'b1;
      if (wait_q == WAIT_W'(WBA_MAX_WAIT - 1)) begin
        state_d = ST_FORCE;
      end
    end
    stall_d = (state_d == ST_FORCE);
  end

  assign bus.cp_ready   = cp_ready_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.stall_pipe = stall_q;
  assign bus.pend_cnt   = fifo_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - Directed and random checks of wb_port_arbiter against a queue-based model
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
    bit               live;
  } ent_t;

  ent_t             model_q[$];
  int               waited    = 0;
  bit               forcing   = 1'b0;
  bit               exp_we    = 1'b0;
  bit               exp_stall = 1'b0;
  bit               exp_ready = 1'b0;
  logic [ASIZE-1:0] exp_addr  = '0;
  logic [DSIZE-1:0] exp_data  = '0;
  int               exp_cnt   = 0;
  int               n_checks  = 0;
  int               n_fail    = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(logic [ASIZE-1:0] a, logic [DSIZE-1:0] d);
    exp_we   = 1'b1;
    exp_addr = a;
    exp_data = d;
  endtask

  // Predicts the registered outputs of the coming cycle from the inputs now on the bus.
  task automatic model_update();
    ent_t e;
    bit   accept, popped, had;
    accept = bus.cp_valid && exp_ready;
    exp_we = 1'b0;
    if (rst) begin
      model_q.delete();
      waited    = 0;
      forcing   = 1'b0;
      exp_ready = 1'b0;
      exp_stall = 1'b0;
      exp_cnt   = 0;
      return;
    end
    had    = (model_q.size() > 0);
    popped = 1'b0;
    if (forcing) begin
      e      = model_q.pop_front();
      popped = 1'b1;
      if (e.live) model_write(e.addr, e.data);
      forcing = 1'b0;
    end else begin
      if (had && (!model_q[0].live || !bus.wb_we)) begin
        e      = model_q.pop_front();
        popped = 1'b1;
        if (e.live) model_write(e.addr, e.data);
      end
      if (bus.wb_we) begin
        model_write(bus.wb_waddr, bus.wb_wdata);
        foreach (model_q[i]) begin
          if (model_q[i].addr == bus.wb_waddr) model_q[i].live = 1'b0;
        end
      end
    end
    if (popped || !had) waited = 0;
    else waited++;
    if (waited == WBA_MAX_WAIT) forcing = 1'b1;
    if (accept) model_q.push_back('{addr: bus.cp_waddr, data: bus.cp_wdata, live: 1'b1});
    exp_cnt   = model_q.size();
    exp_ready = (model_q.size() < WBA_DEPTH);
    exp_stall = forcing;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("rf_we", bus.rf_we, exp_we);
    if (exp_we) begin
      check("rf_waddr", bus.rf_waddr, exp_addr);
      check("rf_wdata", bus.rf_wdata, exp_data);
    end
    check("stall_pipe", bus.stall_pipe, exp_stall);
    check("cp_ready", bus.cp_ready, exp_ready);
    check("pend_cnt", bus.pend_cnt, exp_cnt);
  endtask

  task automatic idle_inputs();
    bus.wb_we    = 1'b0;
    bus.wb_waddr = '0;
    bus.wb_wdata = '0;
    bus.cp_valid = 1'b0;
    bus.cp_waddr = '0;
    bus.cp_wdata = '0;
  endtask

  task automatic offer(logic [ASIZE-1:0] a, logic [DSIZE-1:0] d);
    bus.cp_valid = 1'b1;
    bus.cp_waddr = a;
    bus.cp_wdata = d;
  endtask

  task automatic pipe(logic we, logic [ASIZE-1:0] a, logic [DSIZE-1:0] d);
    bus.wb_we    = we;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_stall", bus.stall_pipe, 0);
    check("rst_pend_cnt", bus.pend_cnt, 0);
    check("rst_cp_ready", bus.cp_ready, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", bus.cp_ready, 1);

    // Idle offer: write lands two cycles after acceptance
    offer(4'd5, 16'h1234);
    step();
    bus.cp_valid = 1'b0;
    step();
    check("idle_we", bus.rf_we, 1);
    check("idle_addr", bus.rf_waddr, 5);
    check("idle_data", bus.rf_wdata, 16'h1234);
    step();

    // Pipeline priority over a buffered entry
    offer(4'd7, 16'h0777);
    step();
    bus.cp_valid = 1'b0;
    pipe(1'b1, 4'd2, 16'hAAAA);
    step();
    check("prio_pipe_addr", bus.rf_waddr, 2);
    check("prio_pipe_data", bus.rf_wdata, 16'hAAAA);
    pipe(1'b0, 4'd0, 16'h0);
    step();
    check("prio_ent_addr", bus.rf_waddr, 7);
    check("prio_ent_data", bus.rf_wdata, 16'h0777);
    step();

    // Starvation forces the buffered entry out, then the held pipeline write follows
    offer(4'd3, 16'h3333);
    pipe(1'b1, 4'd1, 16'h1000);
    step();
    bus.cp_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      pipe(1'b1, 4'd1, 16'(16'h1000 + k));
      step();
    end
    check("starve_stall", bus.stall_pipe, 1);
    pipe(1'b1, 4'd1, 16'h1004);
    step();
    check("force_addr", bus.rf_waddr, 3);
    check("force_data", bus.rf_wdata, 16'h3333);
    check("force_unstall", bus.stall_pipe, 0);
    step();
    check("held_pipe_data", bus.rf_wdata, 16'h1004);
    pipe(1'b0, 4'd0, 16'h0);
    step();

    // Write-after-write cancel
    offer(4'd9, 16'h9999);
    step();
    bus.cp_valid = 1'b0;
    pipe(1'b1, 4'd9, 16'h5A5A);
    step();
    check("waw_addr", bus.rf_waddr, 9);
    check("waw_data", bus.rf_wdata, 16'h5A5A);
    pipe(1'b0, 4'd0, 16'h0);
    step();
    check("waw_no_write", bus.rf_we, 0);
    check("waw_cnt", bus.pend_cnt, 0);
    step();

    // Full buffer back-pressure
    offer(4'd4, 16'h4444);
    pipe(1'b1, 4'd0, 16'h0F00);
    step();
    offer(4'd6, 16'h6666);
    step();
    check("full_ready", bus.cp_ready, 0);
    check("full_cnt", bus.pend_cnt, 2);
    offer(4'd8, 16'h8888);
    step();
    pipe(1'b0, 4'd0, 16'h0);
    step();
    check("full_pop_ready", bus.cp_ready, 1);
    check("full_pop_addr", bus.rf_waddr, 4);
    step();
    check("full_third_cnt", bus.pend_cnt, 1);
    check("full_second_addr", bus.rf_waddr, 6);
    bus.cp_valid = 1'b0;
    step();
    check("full_third_addr", bus.rf_waddr, 8);
    check("full_third_data", bus.rf_wdata, 16'h8888);
    step();

    // Reset while forcing
    offer(4'd3, 16'h3131);
    pipe(1'b1, 4'd1, 16'h2222);
    step();
    bus.cp_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("rstf_stall", bus.stall_pipe, 1);
    rst = 1'b1;
    step();
    check("rstf_we", bus.rf_we, 0);
    check("rstf_addr", bus.rf_waddr, 0);
    check("rstf_data", bus.rf_wdata, 0);
    check("rstf_stall0", bus.stall_pipe, 0);
    check("rstf_cnt", bus.pend_cnt, 0);
    check("rstf_ready0", bus.cp_ready, 0);
    rst = 1'b0;
    idle_inputs();
    step();
    check("rstf_ready1", bus.cp_ready, 1);
    step();
    check("rstf_dropped", bus.rf_we, 0);

    // Random traffic with occasional resets; wb_* are held while the pipe is stalled
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!exp_stall) begin
        bus.wb_we    = ($urandom_range(0, 9) < ((c % 400) < 200 ? 8 : 3));
        bus.wb_waddr = 4'($urandom_range(0, 3));
        bus.wb_wdata = 16'($urandom);
      end
      bus.cp_valid = ($urandom_range(0, 2) != 0);
      bus.cp_waddr = 4'($urandom_range(0, 3));
      bus.cp_wdata = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); reset rst, synchronous, active-high; clock clk.
REQ-002 SHALL have wb_we (input, 1): write enable from the pipeline MEM/WB stage.
REQ-003 SHALL have wb_waddr (input, ASIZE): pipeline write address.
REQ-004 SHALL have wb_wdata (input, DSIZE): pipeline write data, already selected between ALU result and memory data.
REQ-005 SHALL have cp_valid (input, 1), cp_waddr (input, ASIZE) and cp_wdata (input, DSIZE): multi-cycle unit result offer.
REQ-006 SHALL have cp_ready (output, 1): result buffer can accept an offer.
REQ-007 SHALL have rf_we (output, 1), rf_waddr (output, ASIZE) and rf_wdata (output, DSIZE): the single register-file write port.
REQ-008 SHALL have stall_pipe (output, 1): freezes the pipeline at the MEM/WB stage.
REQ-009 SHALL have pend_cnt (output, 2): number of occupied buffer entries (0..2).

Function
REQ-010 SHALL accept a cp offer when cp_valid=1 and cp_ready=1 in the same cycle, and push it into a 2-entry in-order buffer.
REQ-011 SHALL drive cp_ready as a registered signal equal to (occupancy after this cycle's push/pop < 2).
REQ-012 SHALL register all rf_* outputs, giving 1-cycle latency from the granted source to rf_we.
REQ-013 SHALL run FSM states IDLE (buffer empty), PEND (buffer non-empty) and FORCE (starvation override).
REQ-014 In IDLE and PEND, SHALL grant the pipeline whenever wb_we=1; otherwise SHALL pop the valid buffer head to the port.
REQ-015 In PEND, a wait counter SHALL increment on each cycle the head is not popped, and SHALL clear on every pop.
REQ-016 When the wait counter reaches WBA_MAX_WAIT (3), SHALL enter FORCE with stall_pipe=1 registered.
REQ-017 In FORCE, SHALL pop the head regardless of wb_we and ignore wb_*; the upstream stage holds wb_* during stall_pipe.
REQ-018 On leaving FORCE, SHALL go to PEND if the buffer is still non-empty, otherwise to IDLE; stall_pipe SHALL then deassert.
REQ-019 On a pipeline grant, SHALL clear the valid bit of every buffered entry whose address equals wb_waddr (WAW cancel: the pipeline write is younger).
REQ-020 An entry pushed in the same cycle as a matching pipeline grant SHALL NOT be cancelled; it is treated as younger.
REQ-021 SHALL discard an invalid head silently, with no rf write, in the cycle it becomes head; this pop SHALL clear the wait counter.
REQ-022 SHALL support push and pop in the same cycle, including when the buffer is full (cp_ready=0 means no push occurs).
REQ-023 SHALL never assert rf_we for two sources in one cycle, and SHALL never lose an accepted, uncancelled entry.

Reset
REQ-024 On rst=1, SHALL set rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, pend_cnt=0, cp_ready=0, state=IDLE, wait counter=0, and all entries invalid.
REQ-025 SHALL drive cp_ready=1 on the first cycle after rst deasserts.
REQ-026 An assertion of rst mid-FORCE SHALL abort the operation and drop all buffered entries.

Structure
REQ-027 DSIZE and ASIZE SHALL come from define.v; WBA_DEPTH=2 and WBA_MAX_WAIT=3 SHALL be added to define.v.
REQ-028 The buffer SHALL be a sub-module wb_pend_fifo (2 entries, per-entry valid bit, address-match cancel input); the FSM and arbitration SHALL stay in wb_port_arbiter.

Verification (DSIZE=16, ASIZE=4)
REQ-029 Idle offer: cp offer addr=5, data=0x1234, wb_we=0 -> accepted in cycle 0; rf_we=1, addr=5, data=0x1234 in cycle 2.
REQ-030 Priority: wb_we=1 (addr 2, 0xAAAA) with one buffered entry (addr 7) -> pipeline written first, entry written the first cycle wb_we=0.
REQ-031 Starvation: one buffered entry with wb_we held at 1 -> stall_pipe=1 after 3 waiting cycles; entry written in FORCE; stall_pipe=0 the cycle after; held pipeline write follows.
REQ-032 WAW cancel: buffered entry addr=9, then pipeline write addr=9 -> entry discarded, only the pipeline value is written, pend_cnt goes to 0.
REQ-033 Full: two offers back-to-back with wb_we=1 -> cp_ready=0 after the second push; third offer held; accepted in the cycle after the first pop.
REQ-034 Reset mid-FORCE: rst=1 -> next cycle all outputs 0 and pend_cnt=0; cp_ready=1 on the following cycle.
